// File: rtl/clock_s_pkg.sv
// Shared types and default constants for the seconds-based alarm timer.
package clock_s_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  localparam int TICKS_PER_SEC_DEF = 32767;
  localparam int ALARM_W_DEF       = 8;
endpackage

// File: rtl/clock_s_alarm_sec_tick_gen.sv
// Prescaler: counts clock cycles while enabled and emits a one-cycle sec_tick
// on the cycle it wraps from TICKS_PER_SEC-1 back to 0.
module sec_tick_gen
  import clock_s_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic Clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;

  assign sec_tick = en && (presc == TERM);

  always_ff @(posedge Clk) begin
    if (rst || clr)
      presc <= '0;
    else if (en)
      presc <= sec_tick ? '0 : presc + 1'b1;
  end
endmodule

// File: rtl/clock_s_alarm.sv
// Seconds alarm timer: start latches alarm, pluse fires alarm*TICKS_PER_SEC
// cycles later. Define CLOCK_S_REPEAT_EN for periodic re-arm after each pulse.
module clock_s_alarm
  import clock_s_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int ALARM_W       = ALARM_W_DEF
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ALARM_W-1:0] alarm,
  output logic               pluse
);
`ifdef CLOCK_S_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  state_t             state, state_nxt;
  logic [ALARM_W-1:0] alarm_q, sec_cnt, sec_inc;
  logic               sec_tick, sec_hit, rearm, pluse_nxt;

  assign sec_inc = sec_cnt + 1'b1;
  assign sec_hit = (state == RUN) && sec_tick && (sec_inc == alarm_q);
  assign rearm   = REPEAT && (alarm_q != '0);

  // The prescaler wraps to 0 on the hit edge, so in repeat mode the FIRE
  // cycle already counts as the first cycle of the next period.
  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .Clk      (Clk),
    .rst      (rst),
    .clr      (start || (state == IDLE)),
    .en       ((state == RUN) || ((state == FIRE) && rearm)),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge Clk) begin
    if (rst) begin
      state <= IDLE;
      pluse <= 1'b0;
    end else begin
      state <= state_nxt;
      pluse <= pluse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = (alarm == '0) ? FIRE : RUN;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (sec_hit) state_nxt = FIRE;
        FIRE:    state_nxt = rearm ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pluse_nxt = (state_nxt == FIRE);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      alarm_q <= '0;
      sec_cnt <= '0;
    end else if (start) begin
      alarm_q <= alarm;
      sec_cnt <= '0;
    end else if ((state == RUN) && sec_tick) begin
      sec_cnt <= sec_hit ? '0 : sec_inc;
    end
  end
endmodule

// File: tb/tb_clock_s_alarm.sv
// Bench for clock_s_alarm with a small prescaler; honours CLOCK_S_REPEAT_EN.
module tb_clock_s_alarm;
  localparam int T = 4;
`ifdef CLOCK_S_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] alarm = '0;
  logic       pluse;

  int total = 0;
  int bad = 0;
  int n = 0;
  int t0 = 0;
  int a_m = 0;
  bit act = 1'b0;
  int pcount = 0;

  clock_s_alarm #(.TICKS_PER_SEC(T), .ALARM_W(8)) dut (
    .Clk   (Clk),
    .rst   (rst),
    .start (start),
    .alarm (alarm),
    .pluse (pluse)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%0b exp=%0b", tag, n, got, exp);
    end
  endtask

  // One clock edge; the model expresses the alarm as "pulse at every multiple
  // of alarm*T edges after the last start" (only the first unless repeating).
  task automatic step(input string tag, input bit r, input bit s, input logic [7:0] a);
    int  d;
    bit  exp;
    @(negedge Clk);
    rst = r; start = s; alarm = a;
    @(posedge Clk);
    n++;
    if (r) act = 1'b0;
    else if (s) begin act = 1'b1; t0 = n; a_m = int'(a); end
    #1;
    d = n - t0;
    if (!act) exp = 1'b0;
    else if (a_m == 0) exp = (d == 0);
    else exp = (d > 0) && (d % (a_m * T) == 0) && (REP || d == a_m * T);
    if (pluse === 1'b1) pcount++;
    check(tag, pluse, exp);
  endtask

  task automatic idle(input string tag, input int k);
    for (int i = 0; i < k; i++) step(tag, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    // reset dominates start
    step("reset", 1'b1, 1'b1, 8'd3);
    check("reset_pluse", pluse, 1'b0);
    idle("post_reset", 2 * T);
    check("post_reset_cnt", pcount != 0, 1'b0);

    // long one-shot: pulse at edge 100 after start
    pcount = 0;
    step("a25_start", 1'b0, 1'b1, 8'd25);
    idle("a25_run", 110);
    check("a25_cnt", pcount == 1, 1'b1);

    // rst mid-run cancels the pulse
    pcount = 0;
    step("a25b_start", 1'b0, 1'b1, 8'd25);
    idle("a25b_run", 40);
    step("a25b_rst", 1'b1, 1'b0, 8'd0);
    idle("a25b_after", 120);
    check("a25b_cnt", pcount == 0, 1'b1);

    // alarm=0 fires right after the start edge
    pcount = 0;
    step("a0_start", 1'b0, 1'b1, 8'd0);
    idle("a0_after", 12);
    check("a0_cnt", pcount == 1, 1'b1);

    // restart at cycle 20 with alarm=3: pulse at 32, none at 40
    pcount = 0;
    step("rs_start", 1'b0, 1'b1, 8'd10);
    idle("rs_run", 19);
    step("rs_restart", 1'b0, 1'b1, 8'd3);
    idle("rs_after", 30);
    check("rs_cnt", pcount == (REP ? 2 : 1), 1'b1);

    // alarm=2: pulse at 8 (and 16, 24 when repeating)
    step("rp_rst", 1'b1, 1'b0, 8'd0);
    pcount = 0;
    step("rp_start", 1'b0, 1'b1, 8'd2);
    idle("rp_run", 26);
    check("rp_cnt", pcount == (REP ? 3 : 1), 1'b1);

    // start held several cycles: counting begins after the last one
    step("held0", 1'b0, 1'b1, 8'd1);
    step("held1", 1'b0, 1'b1, 8'd4);
    step("held2", 1'b0, 1'b1, 8'd2);
    idle("held_run", 12);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           8'($urandom_range(0, 11)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
